// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes and main-control operation classes for the ID/EX ALU control stage.
// M-extension codes are only produced when ALU_CTRL_M_EXT_EN is defined.
package alu_ctrl_pkg;

  typedef logic [4:0] code_t;

  localparam code_t ALU_ADD    = 5'd0;
  localparam code_t ALU_SUB    = 5'd1;
  localparam code_t ALU_AND    = 5'd2;
  localparam code_t ALU_OR     = 5'd3;
  localparam code_t ALU_XOR    = 5'd4;
  localparam code_t ALU_SLT    = 5'd5;
  localparam code_t ALU_SLTU   = 5'd6;
  localparam code_t ALU_SLL    = 5'd7;
  localparam code_t ALU_SRL    = 5'd8;
  localparam code_t ALU_SRA    = 5'd9;
  localparam code_t ALU_MUL    = 5'd16;
  localparam code_t ALU_MULH   = 5'd17;
  localparam code_t ALU_MULHSU = 5'd18;
  localparam code_t ALU_MULHU  = 5'd19;
  localparam code_t ALU_DIV    = 5'd20;
  localparam code_t ALU_DIVU   = 5'd21;
  localparam code_t ALU_REM    = 5'd22;
  localparam code_t ALU_REMU   = 5'd23;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_ILL   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // alt selects the SUB/SRA variants of funct3 000/101
  function automatic code_t base_code(input logic [2:0] f3, input logic alt);
    code_t c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  function automatic code_t m_code(input logic [2:0] f3);
    code_t c;
    case (f3)
      3'b000:  c = ALU_MUL;
      3'b001:  c = ALU_MULH;
      3'b010:  c = ALU_MULHSU;
      3'b011:  c = ALU_MULHU;
      3'b100:  c = ALU_DIV;
      3'b101:  c = ALU_DIVU;
      3'b110:  c = ALU_REM;
      default: c = ALU_REMU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_decode.sv
// Combinational ALU control decode: main-control class plus funct fields to code/muldiv/illegal.
// funct7=0000001 on R-type decodes to M ops only when ALU_CTRL_M_EXT_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 5
) (
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              op5,
  output logic [CTRL_W-1:0] code,
  output logic              muldiv,
  output logic              illegal
);

  code_t code5;

  always_comb begin
    code5   = ALU_ADD;
    muldiv  = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      ALU_OP_ADD: code5 = ALU_ADD;
      ALU_OP_SUB: code5 = ALU_SUB;
      ALU_OP_FUNCT: begin
        if (op5) begin
          if (funct7 == F7_BASE) begin
            code5 = base_code(funct3, 1'b0);
          end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
            code5 = base_code(funct3, 1'b1);
`ifdef ALU_CTRL_M_EXT_EN
          end else if (funct7 == F7_MULDIV) begin
            code5  = m_code(funct3);
            muldiv = 1'b1;
`endif
          end else begin
            illegal = 1'b1;
          end
        end else begin
          // I-type: funct7 is immediate bits except for the shift encodings
          if (funct3 == 3'b001 && funct7 != F7_BASE) begin
            illegal = 1'b1;
          end else if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) begin
            illegal = 1'b1;
          end else begin
            code5 = base_code(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
          end
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign code = CTRL_W'(code5);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ALU control stage between ID and EX: decode, one valid/ready output register, M-op hold counter.
// Define ALU_CTRL_M_EXT_EN to decode RV32M and enable the multi-cycle hold-off.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              op5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              out_muldiv,
  output logic              out_illegal,
  output logic              busy
);

  localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

  logic [CTRL_W-1:0] dec_code;
  logic              dec_muldiv;
  logic              dec_illegal;
  logic [CNT_W-1:0]  hold_cnt;
  logic              accept;
  logic              out_hs;

  alu_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
    .alu_op  (alu_op),
    .funct3  (funct3),
    .funct7  (funct7),
    .op5     (op5),
    .code    (dec_code),
    .muldiv  (dec_muldiv),
    .illegal (dec_illegal)
  );

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and the producer holds its payload until it transfers.
  assign busy     = (hold_cnt != '0);
  assign in_ready = ~busy & ~(out_valid & out_muldiv) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_ctrl    <= '0;
      out_muldiv  <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_ctrl    <= dec_code;
      out_muldiv  <= dec_muldiv;
      out_illegal <= dec_illegal;
    end else if (out_hs) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef ALU_CTRL_M_EXT_EN
  // The M handshake cycle itself is blocked by out_muldiv, so MDU_LAT-1 more cycles suffice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (out_hs && out_muldiv) begin
      hold_cnt <= CNT_W'(MDU_LAT - 1);
    end else if (busy) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end
`else
  assign hold_cnt = '0;
`endif

endmodule
